// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST engine driving a bank of SRAM macros on a shared bus
// and checking the selected macro's Q through a READ_LAT-deep compare pipe.
module sram_march_bist #(
    parameter int NUM_MACROS = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [$clog2(NUM_MACROS)-1:0]  macro_sel,
    input  logic [ADDR_W-1:0]              last_addr,
    input  logic [DATA_W-1:0]              bg,
    input  logic                           stop_on_fail,
    input  logic [NUM_MACROS*DATA_W-1:0]   sram_q,
    output logic [NUM_MACROS-1:0]          sram_cen,
    output logic                           sram_gwen,
    output logic [DATA_W-1:0]              sram_wen,
    output logic [ADDR_W-1:0]              sram_addr,
    output logic [DATA_W-1:0]              sram_din,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [CNT_W-1:0]               fail_count,
    output logic [ADDR_W-1:0]              fail_addr,
    output logic [2:0]                     fail_elem,
    output logic [DATA_W-1:0]              fail_exp,
    output logic [DATA_W-1:0]              fail_act
);
    localparam int SEL_W = $clog2(NUM_MACROS);
    localparam int EW    = ADDR_W + 3 + DATA_W;
    localparam int PW    = READ_LAT * EW;

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_W-1:0]     last_q, last_d, ptr_q, ptr_d, addr_q, addr_d, faddr_q, faddr_d;
    logic [DATA_W-1:0]     bg_q, bg_d, din_q, din_d, fexp_q, fexp_d, fact_q, fact_d;
    logic                  sof_q, sof_d, ph_q, ph_d, gwen_q, gwen_d, lastop_q, lastop_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0]            elem_q, elem_d, opel_q, opel_d, felem_q, felem_d;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [NUM_MACROS-1:0] cen_q, cen_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [READ_LAT-1:0]   pv_q, pv_d;
    logic [PW-1:0]         pd_q, pd_d;
    logic                  two, wr, down, at_end, rd, mism, issue;
    logic [DATA_W-1:0]     data, q_sel;

    always_comb begin
        two     = elem_q != 3'd0 && elem_q != 3'd5;
        wr      = elem_q == 3'd0 || ph_q;
        down    = elem_q == 3'd3 || elem_q == 3'd4;
        data    = ((elem_q == 3'd2 || elem_q == 3'd4) ^ ph_q) ? ~bg_q : bg_q;
        at_end  = down ? ptr_q == '0 : ptr_q == last_q;
        rd      = gwen_q && !(&cen_q);
        q_sel   = sram_q[sel_q*DATA_W +: DATA_W];
        mism    = pv_q[READ_LAT-1] && q_sel != pd_q[PW-EW +: DATA_W];
        state_d = state_q;
        sel_d = sel_q;
        last_d = last_q;
        bg_d = bg_q;
        sof_d = sof_q;
        ptr_d = ptr_q;
        elem_d = elem_q;
        ph_d = ph_q;
        dcnt_d = dcnt_q;
        cen_d = '1;
        gwen_d = 1'b1;
        addr_d = addr_q;
        din_d = din_q;
        opel_d = opel_q;
        lastop_d = 1'b0;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        fcnt_d = fcnt_q;
        faddr_d = faddr_q;
        felem_d = felem_q;
        fexp_d = fexp_q;
        fact_d = fact_q;
        issue = 1'b0;
        pv_d = (pv_q << 1) | READ_LAT'(rd);
        pd_d = (pd_q << EW) | PW'({addr_q, opel_q, din_q});
        if (mism) begin
            fcnt_d = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
            if (fcnt_q == '0) begin
                faddr_d = pd_q[PW-ADDR_W +: ADDR_W];
                felem_d = pd_q[PW-EW+DATA_W +: 3];
                fexp_d  = pd_q[PW-EW +: DATA_W];
                fact_d  = q_sel;
            end
        end
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = ARM;
                sel_d = macro_sel;
                last_d = last_addr;
                bg_d = bg;
                sof_d = stop_on_fail;
                elem_d = '0;
                ptr_d = '0;
                ph_d = 1'b0;
                done_d = 1'b0;
                pass_d = 1'b0;
                fcnt_d = '0;
                faddr_d = '0;
                felem_d = '0;
                fexp_d = '0;
                fact_d = '0;
            end
            ARM: begin
                state_d = RUN;
                busy_d = 1'b1;
                issue = 1'b1;
            end
            RUN, DRAIN: if (abort) begin
                state_d = IDLE;
                busy_d = 1'b0;
                pv_d = '0;
            end else if (state_q == RUN) begin
                if (lastop_q || (mism && sof_q)) begin
                    state_d = DRAIN;
                    dcnt_d = '0;
                end else issue = 1'b1;
            end else if (dcnt_q == 2'(READ_LAT - 1)) begin
                state_d = DONE;
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = fcnt_d == '0;
            end else dcnt_d = dcnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            cen_d = ~(NUM_MACROS'(1) << sel_q);
            gwen_d = ~wr;
            addr_d = ptr_q;
            din_d = data;
            opel_d = elem_q;
            lastop_d = elem_q == 3'd5 && at_end;
            // r,w pairs stay on one address; the pointer only moves after the second op
            if (two && !ph_q) ph_d = 1'b1;
            else begin
                ph_d = 1'b0;
                elem_d = at_end ? elem_q + 3'd1 : elem_q;
                ptr_d = at_end ? ((elem_q == 3'd2 || elem_q == 3'd3) ? last_q : '0)
                               : down ? ptr_q - 1'b1 : ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q <= '0;
            last_q <= '0;
            bg_q <= '0;
            sof_q <= 1'b0;
            ptr_q <= '0;
            elem_q <= '0;
            ph_q <= 1'b0;
            dcnt_q <= '0;
            cen_q <= '1;
            gwen_q <= 1'b1;
            addr_q <= '0;
            din_q <= '0;
            opel_q <= '0;
            lastop_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fcnt_q <= '0;
            faddr_q <= '0;
            felem_q <= '0;
            fexp_q <= '0;
            fact_q <= '0;
            pv_q <= '0;
            pd_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            last_q <= last_d;
            bg_q <= bg_d;
            sof_q <= sof_d;
            ptr_q <= ptr_d;
            elem_q <= elem_d;
            ph_q <= ph_d;
            dcnt_q <= dcnt_d;
            cen_q <= cen_d;
            gwen_q <= gwen_d;
            addr_q <= addr_d;
            din_q <= din_d;
            opel_q <= opel_d;
            lastop_q <= lastop_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fcnt_q <= fcnt_d;
            faddr_q <= faddr_d;
            felem_q <= felem_d;
            fexp_q <= fexp_d;
            fact_q <= fact_d;
            pv_q <= pv_d;
            pd_q <= pd_d;
        end
    end

    assign sram_cen   = cen_q;
    assign sram_gwen  = gwen_q;
    assign sram_wen   = {DATA_W{gwen_q}};
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fcnt_q;
    assign fail_addr  = faddr_q;
    assign fail_elem  = felem_q;
    assign fail_exp   = fexp_q;
    assign fail_act   = fact_q;
endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: March C- BIST bench with a behavioural SRAM bank, stuck-at fault
// injection, and an op-list reference model checked against the bus every cycle.
module tb_sram_march_bist;
    localparam int NM = 4, AW = 10, DW = 8, RL = 1, CW = 16;

    logic              clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, stop_on_fail = 1'b0;
    logic [1:0]        macro_sel = '0;
    logic [AW-1:0]     last_addr = '0;
    logic [DW-1:0]     bg = '0;
    logic [NM*DW-1:0]  sram_q;
    logic [NM-1:0]     sram_cen;
    logic              sram_gwen, busy, done, pass;
    logic [DW-1:0]     sram_wen, sram_din, fail_exp, fail_act;
    logic [AW-1:0]     sram_addr, fail_addr;
    logic [CW-1:0]     fail_count;
    logic [2:0]        fail_elem;

    sram_march_bist #(.NUM_MACROS(NM), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .macro_sel(macro_sel),
        .last_addr(last_addr), .bg(bg), .stop_on_fail(stop_on_fail), .sram_q(sram_q),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_din(sram_din), .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_exp(fail_exp), .fail_act(fail_act)
    );

    always #5 clk = ~clk;

    // SRAM bank: unselected macros babble random Q so a wrong slice shows up
    logic [DW-1:0] mem [NM][1024];
    logic [DW-1:0] qv [NM];
    logic [DW-1:0] fmask [NM];
    always @(posedge clk)
        for (int i = 0; i < NM; i++)
            if (!sram_cen[i]) begin
                if (!sram_gwen) mem[i][sram_addr] <= sram_din;
                else qv[i] <= mem[i][sram_addr] & ~fmask[i];
            end else qv[i] <= DW'($urandom);
    always_comb for (int i = 0; i < NM; i++) sram_q[i*DW +: DW] = qv[i];

    typedef struct { bit w; int a; logic [DW-1:0] d; int e; } op_t;
    op_t ops[$];
    int n_cmp = 0, n_bad = 0;
    int m_issued, m_cnt, m_faddr, m_felem;
    logic [DW-1:0] m_fexp, m_fact;
    int obs_ops, last_n, last_a;
    logic last_gwen;

    task automatic chk(bit ok, string name, string detail);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic void push(bit w, int a, logic [DW-1:0] d, int e);
        op_t o;
        o.w = w; o.a = a; o.d = d; o.e = e;
        ops.push_back(o);
    endfunction

    function automatic void build(int last, logic [DW-1:0] b);
        ops.delete();
        for (int e = 0; e < 6; e++)
            for (int k = 0; k <= last; k++) begin
                int a;
                a = (e == 3 || e == 4) ? last - k : k;
                case (e)
                    0: push(1, a, b, e);
                    1, 3: begin push(0, a, b, e); push(1, a, ~b, e); end
                    2, 4: begin push(0, a, ~b, e); push(1, a, b, e); end
                    default: push(0, a, b, e);
                endcase
            end
    endfunction

    // Replays the op list on an abstract memory; a stopping fail cuts the list READ_LAT+1 ops later
    function automatic void predict(bit sof, logic [DW-1:0] fm);
        logic [DW-1:0] m [int];
        logic [DW-1:0] act;
        m_issued = ops.size(); m_cnt = 0; m_faddr = 0; m_felem = 0; m_fexp = '0; m_fact = '0;
        for (int i = 0; i < m_issued; i++)
            if (ops[i].w) m[ops[i].a] = ops[i].d;
            else begin
                act = m[ops[i].a] & ~fm;
                if (act != ops[i].d) begin
                    if (m_cnt == 0) begin
                        m_faddr = ops[i].a; m_felem = ops[i].e; m_fexp = ops[i].d; m_fact = act;
                        if (sof && i + RL + 1 < m_issued) m_issued = i + RL + 1;
                    end
                    m_cnt++;
                end
            end
    endfunction

    function automatic bit at_reset();
        return sram_cen == '1 && sram_gwen && sram_wen == '1 && sram_addr == '0 && sram_din == '0 &&
               !busy && !done && !pass && fail_count == '0 && fail_addr == '0 && fail_elem == '0 &&
               fail_exp == '0 && fail_act == '0;
    endfunction

    task automatic run(int sel, int last, logic [DW-1:0] b, bit sof, int fmac, int fbit,
                       int abort_at, int rst_at, output int done_n);
        int limit;
        bit opc, ok;
        logic [NM-1:0] ecen;
        for (int i = 0; i < NM; i++) fmask[i] = '0;
        if (fmac >= 0) fmask[fmac][fbit] = 1'b1;
        build(last, b);
        predict(sof, fmask[sel]);
        done_n = -1; obs_ops = 0; last_n = -1; last_a = -1; last_gwen = 1'b1;
        @(negedge clk);
        macro_sel = 2'(sel); last_addr = AW'(last); bg = b; stop_on_fail = sof; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        macro_sel = 2'($urandom); last_addr = AW'($urandom); bg = DW'($urandom); stop_on_fail = 1'($urandom);
        chk(!busy && !done && !pass && sram_cen == '1 && fail_count == '0 && fail_addr == '0 &&
            fail_elem == '0 && fail_exp == '0 && fail_act == '0, "start_clear",
            $sformatf("busy=%b done=%b pass=%b cen=%b cnt=%0d want all cleared", busy, done, pass, sram_cen, fail_count));
        limit = m_issued + RL + 1;
        for (int n = 1; n <= limit + 4; n++) begin
            @(negedge clk);
            if (sram_cen != '1) begin obs_ops++; last_n = n; last_a = int'(sram_addr); last_gwen = sram_gwen; end
            opc = n <= m_issued;
            ecen = opc ? ~(NM'(1) << sel) : '1;
            ok = sram_cen == ecen && busy == (n < limit) && done == (n == limit);
            if (opc) ok &= sram_gwen == !ops[n-1].w && sram_wen == {DW{!ops[n-1].w}} &&
                           sram_addr == AW'(ops[n-1].a) && (!ops[n-1].w || sram_din == ops[n-1].d);
            else ok &= sram_gwen && sram_wen == '1;
            chk(ok, "bus", $sformatf("cyc %0d got cen=%b gwen=%b addr=%0d din=%h busy=%b done=%b want cen=%b op=%0s",
                n, sram_cen, sram_gwen, sram_addr, sram_din, busy, done, ecen,
                opc ? $sformatf("%0s a=%0d d=%h", ops[n-1].w ? "w" : "r", ops[n-1].a, ops[n-1].d) : "idle"));
            if (n == limit) begin
                done_n = n;
                chk(pass == (m_cnt == 0) && fail_count == CW'(m_cnt) && fail_addr == AW'(m_faddr) &&
                    fail_elem == 3'(m_felem) && fail_exp == m_fexp && fail_act == m_fact, "result",
                    $sformatf("got pass=%b cnt=%0d addr=%0d elem=%0d exp=%h act=%h want pass=%b cnt=%0d addr=%0d elem=%0d exp=%h act=%h",
                    pass, fail_count, fail_addr, fail_elem, fail_exp, fail_act, m_cnt == 0, m_cnt, m_faddr, m_felem, m_fexp, m_fact));
                break;
            end
            if (n == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk(sram_cen == '1 && !busy && !done, "abort",
                    $sformatf("got cen=%b busy=%b done=%b want cen=1111 busy=0 done=0", sram_cen, busy, done));
                return;
            end
            if (n == rst_at) begin
                #2 rst = 1'b1;
                #1 chk(at_reset(), "async_rst",
                       $sformatf("got cen=%b busy=%b addr=%0d din=%h want reset values before clk", sram_cen, busy, sram_addr, sram_din));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        if (done_n < 0) chk(1'b0, "timeout", $sformatf("done never rose, want it at cycle %0d", limit));
    endtask

    initial begin
        int dn;
        for (int i = 0; i < NM; i++) begin fmask[i] = '0; qv[i] = '0; end
        #1 rst = 1'b1;
        #2 chk(at_reset(), "reset", $sformatf("got cen=%b busy=%b done=%b want reset values", sram_cen, busy, done));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(2, 3, 8'h00, 1'b0, -1, 0, 0, 0, dn);
        chk(dn == 42, "t1_done_edge", $sformatf("got %0d want 42", dn));
        chk(pass && fail_count == '0, "t1_pass", $sformatf("got pass=%b cnt=%0d want 1/0", pass, fail_count));

        run(1, 7, 8'h00, 1'b0, 1, 3, 0, 0, dn);
        chk(!pass && fail_count == 16, "t2_count", $sformatf("got pass=%b cnt=%0d want 0/16", pass, fail_count));
        chk(fail_elem == 3'd2 && fail_addr == '0, "t2_where", $sformatf("got elem=%0d addr=%0d want 2/0", fail_elem, fail_addr));
        chk(fail_exp == 8'hFF && fail_act == 8'hF7, "t2_data", $sformatf("got exp=%h act=%h want ff/f7", fail_exp, fail_act));

        run(1, 7, 8'h00, 1'b1, 1, 3, 0, 0, dn);
        chk(fail_count == 1, "t3_count", $sformatf("got %0d want 1", fail_count));
        chk(last_n == 26 && !last_gwen && last_a == 0, "t3_last_op",
            $sformatf("got cyc=%0d gwen=%b addr=%0d want 26/0/0", last_n, last_gwen, last_a));
        chk(dn == 28, "t3_done_edge", $sformatf("got %0d want 28", dn));

        run(2, 3, 8'h3C, 1'b0, -1, 0, 15, 0, dn);
        run(2, 3, 8'h3C, 1'b0, -1, 0, 0, 0, dn);
        chk(pass && fail_count == '0 && fail_act == '0, "t5_rerun", $sformatf("got pass=%b cnt=%0d want 1/0", pass, fail_count));

        run(0, 0, 8'hA5, 1'b0, -1, 0, 0, 0, dn);
        chk(obs_ops == 10, "t4_ops", $sformatf("got %0d want 10", obs_ops));
        chk(pass, "t4_pass", $sformatf("got %b want 1", pass));

        run(3, 3, 8'h5A, 1'b0, -1, 0, 0, 24, dn);
        run(3, 3, 8'h5A, 1'b0, -1, 0, 0, 0, dn);
        chk(obs_ops == 40 && pass, "t6_full", $sformatf("got ops=%0d pass=%b want 40/1", obs_ops, pass));

        repeat (12) begin
            int fm, fb;
            fm = $urandom_range(0, 1) ? int'($urandom_range(0, NM-1)) : -1;
            fb = int'($urandom_range(0, DW-1));
            run(int'($urandom_range(0, NM-1)), int'($urandom_range(0, 15)), DW'($urandom),
                1'($urandom), fm, fb, 0, 0, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
